alu_181_mul_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_181.sv | 51 +++++
 rtl/alu_181_mul_seq.sv | 113 +++++++++++
 tb/tb_alu_181_mul_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants and FSM encoding for the alu_181 datapath and its sequential multiplier.
package alu_pkg;

  localparam logic [3:0] ALU_OP_ADD     = 4'b1001;
  localparam logic       ALU_MODE_ARITH = 1'b0;
  localparam logic       ALU_CNB_NONE   = 1'b1;

  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_RUN  = 2'b01,
    MS_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/alu_181.sv
// 16-bit 74181-style ALU: four 4-bit slices with group carry lookahead (182-style).
// Data is active-high; carry_in and carry_out are active-low like the original parts.
module alu_181 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_in,
  input  logic             mode,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             equal_out
);

  localparam int unsigned NSLICE = WIDTH / 4;

  if (WIDTH != 16) begin : g_bad_width
    $error("alu_181 supports only WIDTH=16");
  end

  logic [WIDTH-1:0] x, y, g, p, arith;
  logic [NSLICE:0]  sc;

  always_comb begin
    x = ~(a | (b & {WIDTH{op_in[0]}}) | (~b & {WIDTH{op_in[1]}}));
    y = ~((a & ~b & {WIDTH{op_in[2]}}) | (a & b & {WIDTH{op_in[3]}}));
    g = ~y;
    p = ~x;
    sc    = '0;
    arith = '0;
    sc[0] = ~carry_in;
    for (int s = 0; s < int'(NSLICE); s++) begin
      automatic logic gg = 1'b0;
      automatic logic pp = 1'b1;
      automatic logic cy = sc[s];
      // Slice: ripple inside the 181, group generate/propagate out to the lookahead unit
      for (int i = 0; i < 4; i++) begin
        arith[4*s+i] = x[4*s+i] ^ y[4*s+i] ^ cy;
        cy = g[4*s+i] | (p[4*s+i] & cy);
        gg = g[4*s+i] | (p[4*s+i] & gg);
        pp = pp & p[4*s+i];
      end
      sc[s+1] = gg | (pp & sc[s]);
    end
    out       = mode ? ~(x ^ y) : arith;
    carry_out = ~sc[NSLICE];
    equal_out = &out;
  end

endmodule

// File: rtl/alu_181_mul_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier sharing one alu_181 adder.
// One add plus one right shift of {acc_hi,acc_lo} per multiplier bit.
module alu_181_mul_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  if (WIDTH != 16) begin : g_bad_width
    $error("alu_181_mul_seq supports only WIDTH=16");
  end

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_b, alu_out;
  logic             alu_cout_n, alu_eq_unused, alu_c;

  assign alu_b = acc_lo_q[0] ? mcand_q : '0;
  assign alu_c = ~alu_cout_n;

  alu_181 #(.WIDTH(WIDTH)) u_alu (
    .a        (acc_hi_q),
    .b        (alu_b),
    .op_in    (ALU_OP_ADD),
    .mode     (ALU_MODE_ARITH),
    .carry_in (ALU_CNB_NONE),
    .out      (alu_out),
    .carry_out(alu_cout_n),
    .equal_out(alu_eq_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MS_IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MS_IDLE: if (in_valid) state_d = MS_RUN;
      MS_RUN:  if (cnt_q == CNT_W'(WIDTH - 1)) state_d = MS_DONE;
      MS_DONE: if (out_ready) state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  // Datapath: load on accept, add-and-shift in RUN, hold in DONE
  always_comb begin
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    cnt_d    = cnt_q;
    case (state_q)
      MS_IDLE: begin
        if (in_valid) begin
          mcand_d  = a_in;
          acc_lo_d = b_in;
          acc_hi_d = '0;
          cnt_d    = '0;
        end
      end
      MS_RUN: begin
        acc_hi_d = {alu_c, alu_out[WIDTH-1:1]};
        acc_lo_d = {alu_out[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
      end
      MS_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        mcand_d  = '0;
        acc_hi_d = '0;
        acc_lo_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == MS_IDLE);
    out_valid = (state_q == MS_DONE);
    busy      = (state_q == MS_RUN);
    product   = {acc_hi_q, acc_lo_q};
  end

endmodule

// File: tb/tb_alu_181_mul_seq.sv
// Self-checking bench for alu_181_mul_seq: directed table, corner sequences and random pairs vs a*b.
module tb_alu_181_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [15:0] a_in, b_in;
  logic        in_ready, out_valid, busy;
  logic [31:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_181_mul_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    int          stall;
    bit          poke;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, wait for DONE, optional backpressure, then drain.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input int gap, input int stall,
                       input bit poke, output logic [31:0] prod, output int lat, output int busy_cnt);
    int  to;
    bit  ready_bad;
    bit  stable;
    in_valid = 1'b0;
    repeat (gap) tick();
    to = 0;
    while (!in_ready && to < 50) begin
      tick();
      to++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    a_in      = 16'($urandom);
    b_in      = 16'($urandom);
    lat       = 1;
    busy_cnt  = 0;
    ready_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      if (in_ready) ready_bad = 1'b1;
      if (poke && lat == 5) begin
        in_valid = 1'b1;
        a_in = 16'h00FF;
        b_in = 16'h0F0F;
      end
      if (poke && lat == 7) in_valid = 1'b0;
      tick();
      lat++;
    end
    check("in_ready_low_in_run", 64'(ready_bad), 64'd0);
    prod      = product;
    out_ready = 1'b0;
    stable    = 1'b1;
    repeat (stall) begin
      tick();
      if (!out_valid || product !== prod || in_ready) stable = 1'b0;
    end
    check("done_hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("back_to_idle", {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] prod;
    int          lat, bc;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_in = '0;
    b_in = '0;
    tick();
    tick();
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    rst = 1'b0;

    vecs.push_back('{16'd3,    16'd5,    32'h0000_000F, 0,  1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 0,  1'b0});
    vecs.push_back('{16'h0000, 16'h1234, 32'h0000_0000, 0,  1'b0});
    vecs.push_back('{16'h1234, 16'h0000, 32'h0000_0000, 0,  1'b0});
    vecs.push_back('{16'hABCD, 16'h0001, 32'h0000_ABCD, 10, 1'b0});
    vecs.push_back('{16'h8000, 16'h0002, 32'h0001_0000, 0,  1'b0});
    vecs.push_back('{16'h0101, 16'h0202, 32'h0002_0402, 0,  1'b1});
    vecs.push_back('{16'h0001, 16'hFFFF, 32'h0000_FFFF, 3,  1'b0});

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, 0, vecs[i].stall, vecs[i].poke, prod, lat, bc);
      check($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
      check($sformatf("vec%0d_run_cycles", i), 64'(bc), 64'd16);
    end

    // Abort in the middle of RUN: reset must take effect without a clock edge
    a_in = 16'h4321;
    b_in = 16'h5678;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    check("pre_abort_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_async", {61'd0, busy, out_valid, in_ready}, 64'd1);
    check("abort_product", 64'(product), 64'd0);
    tick();
    rst = 1'b0;
    do_op(16'd7, 16'd9, 0, 0, 1'b0, prod, lat, bc);
    check("post_reset_product", 64'(prod), 64'd63);
    check("post_reset_latency", 64'(lat), 64'd17);

    for (int k = 0; k < 2000; k++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k % 16 == 0) ra = 16'hFFFF;
      do_op(ra, rb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), prod, lat, bc);
      check($sformatf("rand%0d_%0h_x_%0h", k, ra, rb), 64'(prod), 64'(32'(ra) * 32'(rb)));
      check($sformatf("rand%0d_latency", k), 64'(lat), 64'd17);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
